i2c_master_write_byte: RTL and testbench



---
 rtl/i2c_pkg.sv | 13 +
 rtl/i2c_quarter_timer.sv | 50 +++++
 rtl/i2c_master_write_byte.sv | 126 ++++++++++++
 tb/tb_i2c_master_write_byte.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C byte-engine types: controller states, SCL quarter phases and
// bus constants used by both the byte writer and the byte reader.
package i2c_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, ACK} state_e;
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} phase_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_quarter_timer.sv
// SCL slot timer: counts QUARTER cycles per phase and walks Q0..Q3.
// Held at Q0/count 0 while not running; stall freezes the quarter count.
module i2c_quarter_timer
  import i2c_pkg::*;
#(
  parameter int QUARTER = 4
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   run,
  input  logic   stall,
  output phase_e phase,
  output logic   quarter_first,
  output logic   quarter_end
);

  localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

  logic [QW-1:0] qcnt_q, qcnt_d;
  phase_e        phase_q, phase_d;

  assign phase         = phase_q;
  assign quarter_first = (qcnt_q == '0);
  assign quarter_end   = run && !stall && (qcnt_q == QW'(QUARTER - 1));

  always_comb begin
    qcnt_d  = qcnt_q;
    phase_d = phase_q;
    if (!run) begin
      qcnt_d  = '0;
      phase_d = Q0;
    end else if (quarter_end) begin
      qcnt_d  = '0;
      phase_d = phase_e'(phase_q + 2'd1);
    end else if (!stall) begin
      qcnt_d = qcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      qcnt_q  <= '0;
      phase_q <= Q0;
    end else begin
      qcnt_q  <= qcnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/i2c_master_write_byte.sv
// I2C master byte transmitter: shifts a byte MSB-first, then samples ACK/NACK.
// Optional build macro I2C_CLOCK_STRETCH_EN honours slave clock stretching in Q2.
module i2c_master_write_byte
  import i2c_pkg::*;
#(
  parameter int QUARTER = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       finish,
  output logic       ack_n,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       scl_in,
  output logic       scl
);

  state_e     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       sda_oe_q, sda_oe_d;
  logic       ack_n_q, ack_n_d;
  logic       finish_q, finish_d;
  logic       scl_park_q, scl_park_d;

  phase_e phase;
  logic   quarter_first;
  logic   quarter_end;
  logic   stall;
  logic   slot_end;

`ifdef I2C_CLOCK_STRETCH_EN
  // A slave holding SCL low keeps the first Q2 cycle frozen until SCL is seen high.
  assign stall = (phase == Q2) && quarter_first && !scl_in;
`else
  logic [1:0] unused_stretch_inputs;
  assign unused_stretch_inputs = {scl_in, quarter_first};
  assign stall = 1'b0;
`endif

  i2c_quarter_timer #(.QUARTER(QUARTER)) u_timer (
    .clock         (clock),
    .reset         (reset),
    .run           (busy),
    .stall         (stall),
    .phase         (phase),
    .quarter_first (quarter_first),
    .quarter_end   (quarter_end)
  );

  assign slot_end = quarter_end && (phase == Q3);
  assign busy     = (state_q != IDLE);
  assign scl      = busy ? ((phase == Q2) || (phase == Q3)) : scl_park_q;
  assign sda_oe   = sda_oe_q;
  assign ack_n    = ack_n_q;
  assign finish   = finish_q;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    sda_oe_d   = sda_oe_q;
    ack_n_d    = ack_n_q;
    finish_d   = 1'b0;
    scl_park_d = scl_park_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d    = SHIFT;
          sr_d       = data_in;
          bit_cnt_d  = '0;
          sda_oe_d   = ~data_in[7];
          scl_park_d = 1'b0;
        end
      end
      SHIFT: begin
        // The next bit goes onto SDA as the new slot's Q0 begins.
        if (slot_end) begin
          sr_d = {sr_q[6:0], 1'b0};
          if (bit_cnt_q == 3'(BITS_PER_BYTE - 1)) begin
            state_d  = ACK;
            sda_oe_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            sda_oe_d  = ~sr_q[6];
          end
        end
      end
      ACK: begin
        if ((phase == Q2) && quarter_end) begin
          ack_n_d = sda_in;
        end
        if (slot_end) begin
          state_d  = IDLE;
          finish_d = 1'b1;
          sda_oe_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      sda_oe_q   <= 1'b0;
      ack_n_q    <= I2C_NACK;
      finish_q   <= 1'b0;
      scl_park_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      sda_oe_q   <= sda_oe_d;
      ack_n_q    <= ack_n_d;
      finish_q   <= finish_d;
      scl_park_q <= scl_park_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_write_byte.sv
// Directed bench for i2c_master_write_byte with a finish-driven scoreboard.
// Build with I2C_CLOCK_STRETCH_EN to expect stretch-extended timing.
module tb_i2c_master_write_byte;

  localparam int QUARTER = 2;
  localparam int BYTE_CYCLES = 36 * QUARTER;
`ifdef I2C_CLOCK_STRETCH_EN
  localparam int STRETCH_EXTRA = 10;
`else
  localparam int STRETCH_EXTRA = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       busy, finish, ack_n, sda_oe, scl;
  logic       sda_in, scl_in;
  logic       slave_release = 1'b1;
  logic       stretch_hold = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    int         finish_cyc;
    int         extra;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  // Open-drain bus model: the slave only ever pulls low.
  assign sda_in = ~sda_oe & slave_release;
  assign scl_in = scl & ~stretch_hold;

  i2c_master_write_byte #(.QUARTER(QUARTER)) dut (
    .clock   (clock),
    .reset   (reset),
    .go      (go),
    .data_in (data_in),
    .busy    (busy),
    .finish  (finish),
    .ack_n   (ack_n),
    .sda_in  (sda_in),
    .sda_oe  (sda_oe),
    .scl_in  (scl_in),
    .scl     (scl)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic rel, input int extra);
    exp_t e;
    slave_release = rel;
    data_in = d;
    go = 1'b1;
    e.data = d;
    e.ack = rel;
    e.finish_cyc = cyc + 1 + BYTE_CYCLES + extra;
    e.extra = extra;
    sb.push_back(e);
    step(1);
    go = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    #1;
    checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Per-byte observation: SDA value seen at each SCL rise, SCL-high and busy cycle totals.
  int         busy_cnt = 0;
  int         high_cnt = 0;
  int         pulses = 0;
  logic [8:0] pattern = '0;
  logic       hi_prev = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      busy_cnt = 0; high_cnt = 0; pulses = 0; pattern = '0; hi_prev = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (busy && scl) begin
        high_cnt++;
        if (!hi_prev) begin
          pattern = {pattern[7:0], sda_oe};
          pulses++;
        end
      end
      hi_prev = busy && scl;
      if (finish) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_finish", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("sda_pattern", 32'(pattern), 32'({~e.data, 1'b0}));
          checkOutput("scl_pulses", 32'(pulses), 32'd9);
          checkOutput("ack_n", 32'(ack_n), 32'(e.ack));
          checkOutput("finish_cycle", 32'(cyc), 32'(e.finish_cyc));
          checkOutput("scl_high_cycles", 32'(high_cnt), 32'(18 * QUARTER + e.extra));
          checkOutput("busy_cycles", 32'(busy_cnt), 32'(BYTE_CYCLES + e.extra));
          checkOutput("busy_at_finish", 32'(busy), 32'd0);
        end
        busy_cnt = 0; high_cnt = 0; pulses = 0; pattern = '0;
      end
    end
  end

  initial begin
    int t;
    exp_t e;
    step(3);
    reset = 1'b0;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_finish", 32'(finish), 32'd0);
    checkOutput("rst_ack_n", 32'(ack_n), 32'd1);
    checkOutput("rst_sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("rst_scl", 32'(scl), 32'd1);
    step(2);

    $display("[TB] byte A5 with ACK");
    applyStimulus(8'hA5, 1'b0, 0);
    waitDrain(BYTE_CYCLES + 20);
    step(2);
    checkOutput("park_scl", 32'(scl), 32'd0);
    checkOutput("park_sda_oe", 32'(sda_oe), 32'd0);

    $display("[TB] reset during slot 4");
    slave_release = 1'b0;
    data_in = 8'h5A;
    go = 1'b1;
    step(1);
    go = 1'b0;
    step(16 * QUARTER + QUARTER - 1);
    checkOutput("pre_abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checkOutput("abort_scl", 32'(scl), 32'd1);
    checkOutput("abort_sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_finish", 32'(finish), 32'd0);
    checkOutput("abort_ack_n", 32'(ack_n), 32'd1);
    step(40 * QUARTER);
    checkOutput("abort_stays_idle", 32'(busy), 32'd0);
    applyStimulus(8'h5A, 1'b0, 0);
    waitDrain(BYTE_CYCLES + 20);
    step(3);

    $display("[TB] byte 00 with NACK");
    applyStimulus(8'h00, 1'b1, 0);
    waitDrain(BYTE_CYCLES + 20);
    step(3);

    $display("[TB] back-to-back FF then 3C");
    slave_release = 1'b0;
    data_in = 8'hFF;
    go = 1'b1;
    t = cyc;
    e.data = 8'hFF; e.ack = 1'b0; e.finish_cyc = t + 1 + BYTE_CYCLES; e.extra = 0;
    sb.push_back(e);
    e.data = 8'h3C; e.ack = 1'b0; e.finish_cyc = t + 2 + 2 * BYTE_CYCLES; e.extra = 0;
    sb.push_back(e);
    step(1);
    data_in = 8'h3C;
    step(BYTE_CYCLES);
    checkOutput("b2b_finish_cycle", 32'(finish), 32'd1);
    step(1);
    go = 1'b0;
    checkOutput("b2b_second_busy", 32'(busy), 32'd1);
    waitDrain(2 * BYTE_CYCLES + 40);
    step(40 * QUARTER);
    checkOutput("b2b_no_third", 32'(busy), 32'd0);

    $display("[TB] go while busy ignored");
    applyStimulus(8'hC3, 1'b0, 0);
    step(10);
    go = 1'b1;
    data_in = 8'h18;
    step(1);
    go = 1'b0;
    data_in = 8'h00;
    waitDrain(BYTE_CYCLES + 20);
    step(40 * QUARTER);
    checkOutput("busy_go_no_retrigger", 32'(busy), 32'd0);

    $display("[TB] slave stretch in slot 3 Q2");
    applyStimulus(8'h96, 1'b0, STRETCH_EXTRA);
    step(14 * QUARTER);
    checkOutput("stretch_scl_high", 32'(scl), 32'd1);
    stretch_hold = 1'b1;
    step(10);
    stretch_hold = 1'b0;
    waitDrain(BYTE_CYCLES + 40);
    step(5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
